// File: rtl/acorn_pkg.sv
// acorn_pkg: shared ACORN-128 widths, FSM states, LFSR tap indices and boolean helpers
package acorn_pkg;
  localparam int STATE_W = 293;
  localparam int PAD_LEN = 256;
  localparam int CA_OFF_PAD = 128;
  localparam int L0 = 289;
  localparam int L1 = 230;
  localparam int L2 = 193;
  localparam int L3 = 154;
  localparam int L4 = 107;
  localparam int L5 = 61;
  typedef enum logic [2:0] {IDLE, LOAD, DATA, PAD, DONE} dec_state_e;
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction
endpackage

// File: rtl/decryption_process_if.sv
// decryption_process_if: ciphertext input stream and plaintext output strobe
interface decryption_process_if;
  logic ct_valid;
  logic ct_bit;
  logic ct_ready;
  logic pt_valid;
  logic pt_bit;
  modport master(output ct_valid, ct_bit, input ct_ready, pt_valid, pt_bit);
  modport slave(input ct_valid, ct_bit, output ct_ready, pt_valid, pt_bit);
endinterface

// File: rtl/acorn_step.sv
// acorn_step: one combinational ACORN-128 state step; dec folds the keystream into the message bit
module acorn_step
  import acorn_pkg::*;
(
  input  logic [STATE_W-1:0] s,
  input  logic               ca,
  input  logic               cb,
  input  logic               m_in,
  input  logic               dec,
  output logic [STATE_W-1:0] s_next,
  output logic               ks
);
  logic [STATE_W-1:0] t;
  logic f;
  logic m;
  always_comb begin
    t = s;
    t[L0] = s[L0] ^ s[235] ^ s[L1];
    t[L1] = s[L1] ^ s[196] ^ s[L2];
    t[L2] = s[L2] ^ s[160] ^ s[L3];
    t[L3] = s[L3] ^ s[111] ^ s[L4];
    t[L4] = s[L4] ^ s[66] ^ s[L5];
    t[L5] = s[L5] ^ s[23] ^ s[0];
    ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
    f = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
    m = dec ? m_in ^ ks : m_in;
    s_next = {f ^ m, t[STATE_W-1:1]};
  end
endmodule

// File: rtl/decryption_process.sv
// decryption_process: serial ACORN-128 ciphertext decryption plus 256-step padding; ACORN_DEC_ZEROIZE_EN hides state/pt outside valid windows
module decryption_process
  import acorn_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [STATE_W-1:0]   state_in,
  input  logic [LEN_W-1:0]     ct_len,
  decryption_process_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic [STATE_W-1:0]   state_out
);
  dec_state_e fsm, fsm_nxt;
  logic [STATE_W-1:0] st, s_next;
  logic [LEN_W-1:0] len, bit_cnt;
  logic [7:0] pad_cnt;
  logic ks, xfer, in_pad, can_start, last_bit;
  assign in_pad = fsm == PAD;
  assign can_start = (fsm == IDLE || fsm == DONE) && start;
  assign xfer = fsm == DATA && bus.ct_valid;
  assign last_bit = bit_cnt == len - 1'b1;
  assign bus.ct_ready = fsm == DATA;
  assign busy = fsm == LOAD || fsm == DATA || in_pad;
  assign done = fsm == DONE;
`ifdef ACORN_DEC_ZEROIZE_EN
  assign state_out = done ? st : '0;
`else
  assign state_out = st;
`endif
  acorn_step u_step (
    .s(st),
    .ca(!in_pad || pad_cnt < 8'(CA_OFF_PAD)),
    .cb(1'b0),
    .m_in(in_pad ? pad_cnt == 8'd0 : bus.ct_bit),
    .dec(!in_pad),
    .s_next(s_next),
    .ks(ks)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) fsm <= IDLE;
    else fsm <= fsm_nxt;
  always_comb begin
    fsm_nxt = fsm;
    if (fsm == IDLE || fsm == DONE) fsm_nxt = start ? LOAD : IDLE;
    else if (fsm == LOAD) fsm_nxt = len == '0 ? PAD : DATA;
    else if (fsm == DATA) fsm_nxt = xfer && last_bit ? PAD : DATA;
    else fsm_nxt = pad_cnt == 8'(PAD_LEN - 1) ? DONE : PAD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= '0;
      len <= '0;
      bit_cnt <= '0;
      pad_cnt <= '0;
      bus.pt_valid <= 1'b0;
      bus.pt_bit <= 1'b0;
    end else begin
      bus.pt_valid <= xfer;
      if (xfer) bus.pt_bit <= bus.ct_bit ^ ks;
`ifdef ACORN_DEC_ZEROIZE_EN
      else bus.pt_bit <= 1'b0;
`endif
      if (can_start) begin
        st <= state_in;
        len <= ct_len;
        bit_cnt <= '0;
        pad_cnt <= '0;
      end else if (xfer || in_pad) st <= s_next;
`ifdef ACORN_DEC_ZEROIZE_EN
      else if (done) st <= '0;
`endif
      if (xfer) bit_cnt <= bit_cnt + 1'b1;
      if (in_pad) pad_cnt <= pad_cnt + 8'd1;
    end
endmodule

// File: tb/tb_decryption_process.sv
// tb_decryption_process: randomized scoreboard bench against a table-driven ACORN-128 reference model
module tb_decryption_process;
  import acorn_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [292:0] state_in = '0;
  logic [15:0] ct_len = '0;
  logic busy, done;
  logic [292:0] state_out;
  decryption_process_if bus();
  decryption_process #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in), .ct_len(ct_len),
    .bus(bus), .busy(busy), .done(done), .state_out(state_out)
  );
  always #5 clk = ~clk;

  int checks = 0, fails = 0, cyc = 0, start_cyc = 0, exp_lat = -1;
  int ready_cnt = 0, pt_cnt = 0, done_cnt = 0;
  bit exp_pt[$];
  int exp_cyc[$];
  logic [292:0] exp_st[$];
  bit ct_src[$];
  bit pt_ref[$];
  logic [292:0] st_ref;
  bit use_ref = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [292:0] act, input logic [292:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Reference: tap tables for the six feedback taps, majority by counting, choose by select.
  function automatic logic [292:0] ref_step(input logic [292:0] s, input bit ca, input bit m_in,
                                             input bit dec, output bit ks);
    int dst[6] = '{289, 230, 193, 154, 107, 61};
    int a[6] = '{235, 196, 160, 111, 66, 23};
    int b[6] = '{230, 193, 154, 107, 61, 0};
    logic [292:0] t = s;
    bit f, m;
    foreach (dst[k]) t[dst[k]] = s[dst[k]] ^ s[a[k]] ^ s[b[k]];
    ks = t[12] ^ t[154] ^ ((int'(t[235]) + int'(t[61]) + int'(t[193])) >= 2) ^ (t[230] ? t[111] : t[66]);
    f = t[0] ^ !t[107] ^ ((int'(t[244]) + int'(t[23]) + int'(t[160])) >= 2) ^ (ca && t[196]);
    m = dec ? m_in ^ ks : m_in;
    t = t >> 1;
    t[292] = f ^ m;
    return t;
  endfunction

  function automatic logic [292:0] ref_pad(input logic [292:0] s);
    bit ks;
    for (int j = 0; j < 256; j++) s = ref_step(s, j < 128, j == 0, 0, ks);
    return s;
  endfunction

  function automatic logic [292:0] rand_state();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
    return r[292:0];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ct_ready"}, bus.ct_ready, 0);
    chk({tag, "_pt_valid"}, bus.pt_valid, 0);
    chk({tag, "_pt_bit"}, bus.pt_bit, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state_out"}, state_out, 0);
  endtask

  always @(negedge clk) begin
    if (bus.ct_ready) ready_cnt++;
    if (bus.pt_valid) begin
      pt_cnt++;
      if (exp_cyc.size() == 0 || exp_pt.size() == 0) flag("pt_unexpected");
      else begin
        chk("pt_bit", bus.pt_bit, exp_pt.pop_front());
        chk("pt_cycle", cyc, exp_cyc.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_st.size() == 0) flag("done_unexpected");
      else chk("final_state", state_out, exp_st.pop_front());
      if (exp_lat >= 0) chk("done_latency", cyc - start_cyc, exp_lat);
    end
`ifdef ACORN_DEC_ZEROIZE_EN
    if (!bus.pt_valid) chk("zeroize_pt_bit", bus.pt_bit, 0);
    if (!done) chk("zeroize_state_out", state_out, 0);
`endif
  end

  task automatic do_run(input logic [292:0] s0, input int len, input bit stall,
                        input int dup_start, input int rst_at);
    logic [292:0] s = s0;
    bit ks, tog = 1, xfer;
    int i = 0, budget = 0, d0, n = 0;
    for (int k = 0; k < len; k++) begin
      s = ref_step(s, 1, ct_src[k], 1, ks);
      exp_pt.push_back(use_ref ? pt_ref[k] : ct_src[k] ^ ks);
    end
    exp_st.push_back(use_ref ? st_ref : ref_pad(s));
    exp_lat = stall ? -1 : len + 258;
    ready_cnt = 0;
    pt_cnt = 0;
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1;
    state_in = s0;
    ct_len = 16'(len);
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 0;
    chk("load_busy", busy, 1);
    chk("load_ct_ready", bus.ct_ready, 0);
    while (i < len && budget < 4 * len + 20) begin
      bus.ct_valid = stall ? tog : 1'b1;
      tog = !tog;
      bus.ct_bit = ct_src[i];
      if (budget == dup_start) begin
        start = 1;
        state_in = rand_state();
        ct_len = 16'($urandom_range(1, 50));
      end
      @(negedge clk);
      xfer = bus.ct_valid && bus.ct_ready;
      if (xfer) exp_cyc.push_back(cyc + 1);
      @(posedge clk);
      #1 start = 0;
      if (xfer) i++;
      budget++;
      if (rst_at >= 0 && i == rst_at) begin
        rst = 0;
        bus.ct_valid = 0;
        #1 chk_reset_vals("midrst");
        exp_pt.delete();
        exp_cyc.delete();
        exp_st.delete();
        @(posedge clk);
        #1 rst = 1;
        return;
      end
    end
    bus.ct_valid = 0;
    if (i < len) flag("feed_timeout");
    if (dup_start >= 0) begin
      repeat (30) @(posedge clk);
      #1 start = 1;
      state_in = rand_state();
      @(posedge clk);
      #1 start = 0;
    end
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) flag("done_timeout");
    #1;
    if (!stall) chk("ready_cycles", ready_cnt, len);
    chk("pt_count", pt_cnt, len);
  endtask

  initial begin
    logic [292:0] s;
    bit ks, p;
    bus.ct_valid = 0;
    bus.ct_bit = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst = 1;
    ct_src.delete();
    do_run('0, 0, 0, -1, -1);
    ct_src = '{1'b1};
    do_run('0, 1, 0, -1, -1);
    s = rand_state();
    st_ref = s;
    ct_src.delete();
    pt_ref.delete();
    for (int k = 0; k < 128; k++) begin
      p = 1'($urandom);
      st_ref = ref_step(st_ref, 1, p, 0, ks);
      pt_ref.push_back(p);
      ct_src.push_back(p ^ ks);
    end
    st_ref = ref_pad(st_ref);
    use_ref = 1;
    do_run(s, 128, 0, -1, -1);
    use_ref = 0;
    s = rand_state();
    ct_src.delete();
    for (int k = 0; k < 8; k++) ct_src.push_back(1'($urandom));
    do_run(s, 8, 0, -1, -1);
    do_run(s, 8, 1, -1, -1);
    s = rand_state();
    ct_src.delete();
    for (int k = 0; k < 16; k++) ct_src.push_back(1'($urandom));
    do_run(s, 16, 0, -1, 5);
    do_run(s, 16, 0, -1, -1);
    s = rand_state();
    ct_src.delete();
    for (int k = 0; k < 20; k++) ct_src.push_back(1'($urandom));
    do_run(s, 20, 0, 5, -1);
    for (int r = 0; r < 4; r++) begin
      int len = $urandom_range(1, 40);
      s = rand_state();
      ct_src.delete();
      for (int k = 0; k < len; k++) ct_src.push_back(1'($urandom));
      do_run(s, len, r[0], -1, -1);
    end
    repeat (3) @(posedge clk);
    if (exp_pt.size() != 0 || exp_st.size() != 0) flag("scoreboard_leftover");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/decryption_process.md
# decryption_process

Serial ACORN-128 ciphertext-processing engine for the decryption side. It takes the 293-bit state left after associated-data processing and consumes ciphertext one bit per accepted cycle, producing plaintext bit `p_i = c_i ^ ks_i` and updating the state with `m_i = p_i`. It then runs the 256-cycle plaintext padding phase and hands the state on to finalization/tag generation. It sits between the associated-data processor and the tag stage, mirroring the encryption-side plaintext processor.

## Interface
- `LEN_W`, default 16: width of the ciphertext bit-length input.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; latch `state_in` and `ct_len`. Ignored unless in IDLE or DONE.
- `state_in`  in  293  state after associated-data processing.
- `ct_len`  in  LEN_W  number of ciphertext bits, 0 to 2^LEN_W-1.
- `ct_valid`  in  1  `ct_bit` valid.
- `ct_bit`  in  1  ciphertext bit, LSB-first stream order.
- `ct_ready`  out  1  high in DATA; a bit transfers when `ct_valid & ct_ready`.
- `pt_valid`  out  1  one-cycle strobe per plaintext bit. No backpressure.
- `pt_bit`  out  1  plaintext bit.
- `busy`  out  1  high in LOAD, DATA, PAD.
- `done`  out  1  one-cycle pulse when padding completes.
- `state_out`  out  293  current state register; final value is valid when `done` is high.

## Operation
- FSM states:
  - IDLE: on `start`, go to LOAD.
  - LOAD: state register is loaded from `state_in`. Next state is DATA, or PAD if `ct_len == 0`.
  - DATA: one step per transfer. On the last bit, go to PAD.
  - PAD: exactly 256 steps with no input. Then go to DONE.
  - DONE: `done` pulses for 1 cycle, then the FSM returns to IDLE. `start` in DONE behaves as in IDLE.
- Per step (`acorn_step`): the six LFSR linear updates run first, then:
  - `ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66)`
  - `f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ (ca & S196) ^ (cb & ks)`
  - shift, with `S292 = f ^ m`.
- Control bits:
  - `cb = 0` for every step.
  - `ca = 1` for all DATA steps and for PAD steps 0..127.
  - `ca = 0` for PAD steps 128..255.
- Message bit:
  - DATA: `m = ct_bit ^ ks` (decrypt mode).
  - PAD step 0: `m = 1`.
  - PAD steps 1..255: `m = 0`.
- Counters:
  - `bit_cnt` is LEN_W wide and counts accepted bits. The last data bit is when `bit_cnt == ct_len-1`.
  - `pad_cnt` is 8 bits and finishes on wrap from 255 to 0.
- `ct_valid` low in DATA is a stall: state and counters hold, and no `pt_valid` is produced.
- `start` while busy is ignored, with no effect on the in-flight operation.
- Reset mid-operation returns to IDLE immediately and discards all progress.

## Timing
- Reset values: `ct_ready=0`, `pt_valid=0`, `pt_bit=0`, `busy=0`, `done=0`, `state_out=0`, all counters 0, FSM in IDLE.
- `start` at cycle t:
  - LOAD at t+1.
  - `ct_ready` and `busy` high from t+2.
- Plaintext latency: `pt_bit`/`pt_valid` are registered and appear 1 cycle after the accepting edge.
- PAD step count is exactly 256 cycles.
- `done` pulses on the cycle after the final PAD step, with final `state_out` stable.
- Total cycles from `start` to `done` with no stalls: `ct_len + 258`.

## Configuration
- Macro `ACORN_DEC_ZEROIZE_EN`.
- When defined:
  - `pt_bit` is forced to 0 whenever `pt_valid` is low.
  - `state_out` reads 0 except in the DONE cycle.
  - The internal state register is cleared on return to IDLE.
- When undefined:
  - `pt_bit` holds its last value.
  - `state_out` always shows the live register.
  - State persists after DONE.

## Structure
- Shared package `acorn_pkg`:
  - `STATE_W=293` and `PAD_LEN=256`.
  - `CA_OFF_PAD=128` (first PAD step with `ca = 0`).
  - FSM state enumeration.
  - Tap index constants.
  - `maj` and `ch` functions.
- Sub-module `acorn_step` is combinational:
  - Inputs: state, `ca`, `cb`, `m_in`, `dec`.
  - Outputs: next state and `ks`.
  - When `dec` is high, `m = m_in ^ ks`.
  - Reused by the encryption and associated-data blocks.

## Test plan
- Zero-length: `state_in=0`, `ct_len=0`, `start` → `ct_ready` never high, no `pt_valid`, `done` exactly 258 cycles after `start`, `state_out` matches reference model.
- Zero state, first bit: `state_in=0`, `ct_len=1`, `ct_bit=1` → `ks=0`, `pt_bit=1` one cycle after transfer, then 256 pad cycles.
- Round trip: encrypt 128 random bits with the C model from a fixed state, feed the ciphertext → `pt` equals the original 128 bits and final `state_out` equals the encryption-side final state.
- Stalls: `ct_len=8`, `ct_valid` toggled 1010… → exactly 8 `pt_valid` pulses, same final state as the no-stall run.
- Reset mid-operation: assert `rst` at bit 5 of 16 → all outputs at reset values, and a new `start` completes correctly.
- `start` during DATA or PAD → ignored, result identical to the run without the extra pulse; check both macro settings of `ACORN_DEC_ZEROIZE_EN`.
